dispatch_router: RTL and testbench

//  Consumer side of the decoded-instruction interface. Accepts one decoded uop per cycle
//  (register fields, ALUOp, Opcode, fu_* flags, func3/func7) over a valid/ready handshake.

---
 rtl/dispatch_pkg.sv | 40 ++++
 rtl/uop_fifo.sv | 57 +++++
 rtl/dispatch_router.sv | 81 ++++++++
 tb/tb_dispatch_router.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: uop record, route encoding, ALUOp/opcode constants and head routing helper
package dispatch_pkg;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] alu_op;
        logic [6:0] opcode;
        logic [2:0] func3;
        logic [6:0] func7;
        logic       fu_alu;
        logic       fu_mem;
        logic       fu_br;
    } uop_t;

    typedef enum logic [1:0] {ROUTE_ALU, ROUTE_MEM, ROUTE_BR, ROUTE_ILLEGAL} fu_route_e;

    localparam logic [2:0] ALUOP_LDST = 3'b000;
    localparam logic [2:0] ALUOP_BR   = 3'b001;
    localparam logic [2:0] ALUOP_R    = 3'b010;
    localparam logic [2:0] ALUOP_I    = 3'b011;
    localparam logic [2:0] ALUOP_LUI  = 3'b100;
    localparam logic [2:0] ALUOP_JALR = 3'b110;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Branch wins over mem, mem over alu: stores and branches also carry fu_alu.
    function automatic fu_route_e route_of(uop_t u);
        return u.fu_br ? ROUTE_BR : u.fu_mem ? ROUTE_MEM : u.fu_alu ? ROUTE_ALU : ROUTE_ILLEGAL;
    endfunction

endpackage

// File: rtl/uop_fifo.sv
// uop_fifo: in-order uop storage with separate count register for full/empty
//   clk, rst_n      clock, async active-low reset
//   flush           clears pointers and count at the next edge, dropping any push
//   push/din        write one uop (caller guarantees !full)
//   pop             drop the head (caller guarantees !empty)
//   dout            head uop, zero when empty
//   full/empty/count occupancy from registered state
module uop_fifo
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  uop_t                       din,
    input  logic                       pop,
    output uop_t                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    uop_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wptr_d = flush ? '0 : wptr_q + AW'(push);
        rptr_d = flush ? '0 : rptr_q + AW'(pop);
        cnt_d  = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= din;
    end

    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign count = cnt_q;
    assign dout  = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/dispatch_router.sv
// dispatch_router: buffers decoded uops and dispatches the head to the ALU, MEM or BR queue
//   clk, rst_n                 clock, async active-low reset
//   flush                      discard all buffered uops (illegal_cnt kept)
//   in_valid/in_ready, in_*    decoded uop input handshake and fields
//   out_uop                    head uop shared by all queues
//   alu/mem/br_valid, _ready   per-queue dispatch handshakes
//   illegal_cnt                saturating count of uops dropped for having no fu flag
module dispatch_router
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_alu_op,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_func3,
    input  logic [6:0]       in_func7,
    input  logic             in_fu_alu,
    input  logic             in_fu_mem,
    input  logic             in_fu_br,
    output uop_t             out_uop,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             br_valid,
    input  logic             br_ready,
    output logic [CNT_W-1:0] illegal_cnt
);
    uop_t                   in_uop;
    logic                   full, empty, push, pop, ill_pop;
    logic [$clog2(DEPTH):0] count;
    fu_route_e              route;
    logic [CNT_W-1:0]       ill_q, ill_d;

    assign in_uop = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, alu_op: in_alu_op, opcode: in_opcode,
                      func3: in_func3, func7: in_func7, fu_alu: in_fu_alu, fu_mem: in_fu_mem,
                      fu_br: in_fu_br};

    uop_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (in_uop),
        .pop   (pop),
        .dout  (out_uop),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign route     = route_of(out_uop);
    assign alu_valid = !empty && route == ROUTE_ALU;
    assign mem_valid = !empty && route == ROUTE_MEM;
    assign br_valid  = !empty && route == ROUTE_BR;
    // Illegal heads leave without any handshake so they never stall the stream.
    assign ill_pop   = !empty && route == ROUTE_ILLEGAL;
    assign pop       = (alu_valid && alu_ready) || (mem_valid && mem_ready) ||
                       (br_valid && br_ready) || ill_pop;

    always_comb ill_d = (ill_pop && !flush && !(&ill_q)) ? ill_q + 1'b1 : ill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ill_q <= '0;
        else        ill_q <= ill_d;
    end

    assign illegal_cnt = ill_q;

endmodule

// File: tb/tb_dispatch_router.sv
// tb_dispatch_router: table-driven per-cycle vectors plus async reset mid-stall sequence
module tb_dispatch_router;
    import dispatch_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [2:0]  in_alu_op = '0, in_func3 = '0;
    logic [6:0]  in_opcode = '0, in_func7 = '0;
    logic        in_fu_alu = 1'b0, in_fu_mem = 1'b0, in_fu_br = 1'b0;
    uop_t        out_uop;
    logic        alu_valid, mem_valid, br_valid;
    logic        alu_ready = 1'b0, mem_ready = 1'b0, br_ready = 1'b0;
    logic [15:0] illegal_cnt;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    dispatch_router #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
        .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
        .in_fu_alu(in_fu_alu), .in_fu_mem(in_fu_mem), .in_fu_br(in_fu_br),
        .out_uop(out_uop), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .br_valid(br_valid),
        .br_ready(br_ready), .illegal_cnt(illegal_cnt)
    );

    // fu and rdy/valid triples are ordered {br, mem, alu}
    typedef struct {
        bit        iv;
        bit [4:0]  rd;
        bit [2:0]  fu;
        bit [2:0]  rdy;
        bit        fl;
        bit        e_ir;
        bit [2:0]  e_v;
        bit [4:0]  e_rd;
        bit [15:0] e_ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t r(bit iv, bit [4:0] rd, bit [2:0] fu, bit [2:0] rdy, bit fl,
                               bit e_ir, bit [2:0] e_v, bit [4:0] e_rd, bit [15:0] e_ill);
        vec_t t;
        t.iv = iv; t.rd = rd; t.fu = fu; t.rdy = rdy; t.fl = fl;
        t.e_ir = e_ir; t.e_v = e_v; t.e_rd = e_rd; t.e_ill = e_ill;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t t);
        in_valid  = t.iv;
        in_rd     = t.rd;
        in_rs1    = t.rd + 5'd1;
        in_rs2    = t.rd + 5'd2;
        {in_fu_br, in_fu_mem, in_fu_alu} = t.fu;
        in_opcode = t.fu == 3'b000 ? 7'h7f : t.fu[2] ? OPC_BRANCH :
                    t.fu[1] ? (t.fu[0] ? OPC_STORE : OPC_LOAD) : OPC_OP;
        in_alu_op = t.fu[2] ? ALUOP_BR : t.fu[1] ? ALUOP_LDST : ALUOP_R;
        in_func3  = 3'b001;
        in_func7  = '0;
        {br_ready, mem_ready, alu_ready} = t.rdy;
        flush     = t.fl;
    endtask

    initial begin
        // 1. reset state
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b000, 0, 0));
        // 2. R-type rd=5
        tbl.push_back(r(1, 5, 3'b001, 3'b111, 0, 1, 3'b000, 0, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b001, 5, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b000, 0, 0));
        // 3. store then BNE: mem then br, never alu
        tbl.push_back(r(1, 7, 3'b011, 3'b111, 0, 1, 3'b000, 0, 0));
        tbl.push_back(r(1, 8, 3'b101, 3'b111, 0, 1, 3'b010, 7, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b100, 8, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b000, 0, 0));
        // 4. five loads with mem_ready low, fill to full, then drain
        tbl.push_back(r(1, 10, 3'b010, 3'b101, 0, 1, 3'b000, 0, 0));
        tbl.push_back(r(1, 11, 3'b010, 3'b101, 0, 1, 3'b010, 10, 0));
        tbl.push_back(r(1, 12, 3'b010, 3'b101, 0, 1, 3'b010, 10, 0));
        tbl.push_back(r(1, 13, 3'b010, 3'b101, 0, 1, 3'b010, 10, 0));
        tbl.push_back(r(1, 14, 3'b010, 3'b101, 0, 0, 3'b010, 10, 0));
        tbl.push_back(r(1, 14, 3'b010, 3'b101, 0, 0, 3'b010, 10, 0));
        tbl.push_back(r(1, 14, 3'b010, 3'b111, 0, 0, 3'b010, 10, 0));
        tbl.push_back(r(1, 14, 3'b010, 3'b111, 0, 1, 3'b010, 11, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b010, 12, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b010, 13, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b010, 14, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b000, 0, 0));
        // 5. ALU rd=1, illegal, ALU rd=2: one-cycle bubble, count 1
        tbl.push_back(r(1, 1, 3'b001, 3'b111, 0, 1, 3'b000, 0, 0));
        tbl.push_back(r(1, 3, 3'b000, 3'b111, 0, 1, 3'b001, 1, 0));
        tbl.push_back(r(1, 2, 3'b001, 3'b111, 0, 1, 3'b000, 0, 0));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b001, 2, 1));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b000, 0, 1));
        // 6. three buffered with alu stalled, flush with a same-cycle push
        tbl.push_back(r(1, 20, 3'b001, 3'b110, 0, 1, 3'b000, 0, 1));
        tbl.push_back(r(1, 21, 3'b001, 3'b110, 0, 1, 3'b001, 20, 1));
        tbl.push_back(r(1, 22, 3'b001, 3'b110, 0, 1, 3'b001, 20, 1));
        tbl.push_back(r(1, 23, 3'b001, 3'b110, 1, 1, 3'b001, 20, 1));
        tbl.push_back(r(0, 0, 3'b000, 3'b110, 0, 1, 3'b000, 0, 1));
        tbl.push_back(r(0, 0, 3'b000, 3'b111, 0, 1, 3'b000, 0, 1));
        // refill two uops behind a stalled ALU for the async reset sequence
        tbl.push_back(r(1, 24, 3'b001, 3'b110, 0, 1, 3'b000, 0, 1));
        tbl.push_back(r(1, 25, 3'b001, 3'b110, 0, 1, 3'b001, 24, 1));
        tbl.push_back(r(0, 0, 3'b000, 3'b110, 0, 1, 3'b001, 24, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d valids", i), 32'({br_valid, mem_valid, alu_valid}), 32'(tbl[i].e_v));
            chk($sformatf("v%0d illegal_cnt", i), 32'(illegal_cnt), 32'(tbl[i].e_ill));
            if (tbl[i].e_v != 3'b000)
                chk($sformatf("v%0d out_rd", i), 32'(out_uop.rd), 32'(tbl[i].e_rd));
        end

        // async reset mid-stall: outputs must clear before any further clock edge
        @(posedge clk);
        #2;
        chk("pre_rst alu_valid", 32'(alu_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async alu_valid", 32'(alu_valid), 32'd0);
        chk("async in_ready", 32'(in_ready), 32'd1);
        chk("async illegal_cnt", 32'(illegal_cnt), 32'd0);
        chk("async out_uop", 32'(out_uop == '0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst valids", 32'({br_valid, mem_valid, alu_valid}), 32'd0);
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
